// File: rtl/v10_amplitude_reader_pkg.sv
// Shared settings for the v10 amplitude reader.
//   package_settings      : ADC front-end sizing (SIZE_ADC_DATA).
//   v10_filter_parameters : trapezoid filter constants, default reader
//                           parameters and the reader state encoding.
package package_settings;
  localparam int SIZE_ADC_DATA = 12;
endpackage

package v10_filter_parameters;
  import package_settings::*;

  // Trapezoid filter geometry (k = rise, l = rise + flat, M = gain growth bits)
  localparam int M_length_var7 = 3;
  localparam int k_var7        = 4;
  localparam int l_var7        = 8;

  localparam int W_DEFAULT            = SIZE_ADC_DATA + M_length_var7 + 1;
  localparam int RISE_LEN_DEFAULT     = k_var7;
  localparam int FLAT_LEN_DEFAULT     = l_var7 - k_var7;
  localparam int HOLDOFF_LEN_DEFAULT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RISE     = 3'd1,
    ST_FLAT     = 3'd2,
    ST_FALL     = 3'd3,
    ST_WAIT_LOW = 3'd4,
    ST_HOLDOFF  = 3'd5
  } amp_state_e;
endpackage

// File: rtl/v10_amplitude_reader_if.sv
// Sample/result bus of the v10 amplitude reader.
//   master : drives in_data/threshold, receives the event results.
//   slave  : the reader itself.
interface v10_amplitude_reader_if
  import v10_filter_parameters::*;
#(
  parameter int W = W_DEFAULT
);
  logic signed [W-1:0] in_data;
  logic signed [W-1:0] threshold;
  logic signed [W-1:0] amp_out;
  logic [31:0]         timestamp;
  logic                pileup;
  logic                amp_valid;
  logic [15:0]         event_count;
  logic                busy;

  modport master (
    output in_data, threshold,
    input  amp_out, timestamp, pileup, amp_valid, event_count, busy
  );

  modport slave (
    input  in_data, threshold,
    output amp_out, timestamp, pileup, amp_valid, event_count, busy
  );
endinterface

// File: rtl/v10_amplitude_reader_holdoff_timer.sv
// Dead-time counter for the amplitude reader.
//   clk, reset : clock, synchronous active-low reset
//   load_i     : reload the counter with LEN
//   count_i    : decrement while non-zero
//   done_o     : this is the last dead-time cycle (count <= 1)
module v10_holdoff_timer #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic count_i,
  output logic done_o
);
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: load wins over decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 16'(LEN);
    end else if (count_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q <= 16'd1);
endmodule

// File: rtl/v10_amplitude_reader.sv
// Trapezoid amplitude reader: triggers on the filter output crossing the
// threshold, checks rise and flat top, captures the flat-top amplitude and
// reports it with the trigger timestamp once the pulse falls (or flags
// pile-up when the fall never comes).
//   clk, reset : clock, synchronous active-low reset
//   bus        : in_data/threshold in; amp_out, timestamp, pileup,
//                amp_valid, event_count, busy out
module v10_amplitude_reader
  import v10_filter_parameters::*;
#(
  parameter int W            = W_DEFAULT,
  parameter int RISE_LEN     = RISE_LEN_DEFAULT,
  parameter int FLAT_LEN     = FLAT_LEN_DEFAULT,
  parameter int SAMPLE_POS   = FLAT_LEN / 2,
  parameter int FALL_TIMEOUT = 2 * RISE_LEN,
  parameter int HOLDOFF_LEN  = HOLDOFF_LEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  v10_amplitude_reader_if.slave  bus
);
  // idx_q counts samples since the trigger sample (trigger = index 0)
  localparam logic [15:0] RISE_LAST = 16'(RISE_LEN - 1);
  localparam logic [15:0] CAP_IDX   = 16'(RISE_LEN + SAMPLE_POS);
  localparam logic [15:0] FLAT_LAST = 16'(RISE_LEN + FLAT_LEN - 1);
  localparam logic [15:0] FALL_TO   = 16'(FALL_TIMEOUT);
  // A zero-length dead time skips the HOLDOFF state entirely
  localparam amp_state_e  POST_ST   = (HOLDOFF_LEN == 0) ? ST_IDLE : ST_HOLDOFF;
  localparam amp_state_e  TRIG_ST   = (RISE_LEN <= 1) ? ST_FLAT : ST_RISE;

  amp_state_e          state_q, state_d;
  logic [31:0]         timebase_q, timebase_d;
  logic [15:0]         idx_q, idx_d;
  logic [15:0]         fall_q, fall_d;
  logic [31:0]         ts_pend_q, ts_pend_d;
  logic signed [W-1:0] amp_pend_q, amp_pend_d;
  logic signed [W-1:0] amp_out_q, amp_out_d;
  logic [31:0]         timestamp_q, timestamp_d;
  logic                pileup_q, pileup_d;
  logic                amp_valid_q, amp_valid_d;
  logic [15:0]         event_count_q, event_count_d;
  logic                above_s;
  logic                ho_load_s, ho_count_s, ho_done_s;

  assign above_s = ($signed(bus.in_data) > $signed(bus.threshold));

  v10_holdoff_timer #(.LEN(HOLDOFF_LEN)) u_holdoff (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ho_load_s),
    .count_i (ho_count_s),
    .done_o  (ho_done_s)
  );

  // Event state machine: next state, pending capture and result strobe
  always_comb begin
    state_d       = state_q;
    timebase_d    = timebase_q + 32'd1;
    idx_d         = idx_q;
    fall_d        = fall_q;
    ts_pend_d     = ts_pend_q;
    amp_pend_d    = amp_pend_q;
    amp_out_d     = amp_out_q;
    timestamp_d   = timestamp_q;
    pileup_d      = pileup_q;
    amp_valid_d   = 1'b0;
    event_count_d = event_count_q;
    ho_load_s     = 1'b0;
    ho_count_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (above_s) begin
          ts_pend_d = timebase_q;
          idx_d     = 16'd1;
          state_d   = TRIG_ST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RISE: begin
        if (!above_s) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 16'd1;
          if (idx_q == RISE_LAST) state_d = ST_FLAT;
          else                    state_d = ST_RISE;
        end
      end
      ST_FLAT: begin
        if (idx_q == CAP_IDX) amp_pend_d = bus.in_data;
        else                  amp_pend_d = amp_pend_q;
        if (!above_s) begin
          state_d   = POST_ST;
          ho_load_s = 1'b1;
        end else begin
          idx_d = idx_q + 16'd1;
          if (idx_q == FLAT_LAST) begin
            state_d = ST_FALL;
            fall_d  = 16'd0;
          end else begin
            state_d = ST_FLAT;
          end
        end
      end
      ST_FALL: begin
        if (!above_s) begin
          amp_valid_d   = 1'b1;
          amp_out_d     = amp_pend_q;
          timestamp_d   = ts_pend_q;
          pileup_d      = 1'b0;
          event_count_d = event_count_q + 16'd1;
          state_d       = POST_ST;
          ho_load_s     = 1'b1;
        end else begin
          fall_d = fall_q + 16'd1;
          // Still above after the timeout: a second pulse has piled up
          if ((fall_q + 16'd1) >= FALL_TO) begin
            amp_valid_d   = 1'b1;
            amp_out_d     = amp_pend_q;
            timestamp_d   = ts_pend_q;
            pileup_d      = 1'b1;
            event_count_d = event_count_q + 16'd1;
            state_d       = ST_WAIT_LOW;
          end else begin
            state_d = ST_FALL;
          end
        end
      end
      ST_WAIT_LOW: begin
        if (!above_s) begin
          state_d   = POST_ST;
          ho_load_s = 1'b1;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_HOLDOFF: begin
        ho_count_s = 1'b1;
        if (ho_done_s) state_d = ST_IDLE;
        else           state_d = ST_HOLDOFF;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, timebase and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      timebase_q    <= 32'd0;
      idx_q         <= 16'd0;
      fall_q        <= 16'd0;
      ts_pend_q     <= 32'd0;
      amp_pend_q    <= '0;
      amp_out_q     <= '0;
      timestamp_q   <= 32'd0;
      pileup_q      <= 1'b0;
      amp_valid_q   <= 1'b0;
      event_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      timebase_q    <= timebase_d;
      idx_q         <= idx_d;
      fall_q        <= fall_d;
      ts_pend_q     <= ts_pend_d;
      amp_pend_q    <= amp_pend_d;
      amp_out_q     <= amp_out_d;
      timestamp_q   <= timestamp_d;
      pileup_q      <= pileup_d;
      amp_valid_q   <= amp_valid_d;
      event_count_q <= event_count_d;
    end
  end

  assign bus.amp_out     = amp_out_q;
  assign bus.timestamp   = timestamp_q;
  assign bus.pileup      = pileup_q;
  assign bus.amp_valid   = amp_valid_q;
  assign bus.event_count = event_count_q;
  assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_v10_amplitude_reader.sv
// Directed, table-driven bench for v10_amplitude_reader (W=16, RISE=4,
// FLAT=4, SAMPLE_POS=2, FALL_TIMEOUT=8, HOLDOFF=2, threshold 100).
module tb_v10_amplitude_reader;
  typedef struct {
    logic               rst_n;
    logic signed [15:0] din;
    logic signed [15:0] thr;
    logic               v;      // strobe expected after this sample
    logic               b;      // busy expected after this sample
    logic signed [15:0] amp;    // strobe amplitude
    logic               pile;   // strobe pileup flag
    int                 ts_idx; // table index of the trigger sample
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  v10_amplitude_reader_if #(.W(16)) bus ();

  v10_amplitude_reader #(
    .W(16), .RISE_LEN(4), .FLAT_LEN(4), .SAMPLE_POS(2),
    .FALL_TIMEOUT(8), .HOLDOFF_LEN(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  vec_t tbl[$];
  int ts_at[512];
  logic signed [15:0] exp_amp = 16'sd0;
  logic               exp_pile = 1'b0;
  logic [31:0]        exp_ts = 32'd0;
  logic [15:0]        exp_cnt = 16'd0;
  int                 vals[8] = '{200, 400, 600, 800, 1000, 1000, 1010, 1000};

  // Reference timebase: counts edges since the last reset edge
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s idx=%0d got=%0h expected=%0h", nm, k, got, exp);
    end
  endtask

  task automatic push(input logic r, input int din, input int thr, input logic v,
                      input logic b, input int amp, input logic p, input int tsi);
    vec_t e;
    e.rst_n = r; e.din = din[15:0]; e.thr = thr[15:0]; e.v = v; e.b = b;
    e.amp = amp[15:0]; e.pile = p; e.ts_idx = tsi;
    tbl.push_back(e);
  endtask

  // First 8 samples of the reference pulse: rise + flat, ends in FALL
  task automatic add_prefix(output int s);
    s = tbl.size();
    for (int j = 0; j < 8; j++) push(1'b1, vals[j], 100, 1'b0, 1'b1, 0, 1'b0, 0);
  endtask

  // Full clean pulse; strobe after the final 50 sample
  task automatic add_clean();
    int s;
    add_prefix(s);
    push(1'b1, 500, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 50, 100, 1'b1, 1'b1, 1010, 1'b0, s);
  endtask

  task automatic run_table();
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      bus.in_data   = tbl[k].din;
      bus.threshold = tbl[k].thr;
      reset         = tbl[k].rst_n;
      ts_at[k]      = cyc;
      @(posedge clk);
      #1;
      if (!tbl[k].rst_n) begin
        exp_amp = 16'sd0; exp_pile = 1'b0; exp_ts = 32'd0; exp_cnt = 16'd0;
      end else if (tbl[k].v) begin
        exp_amp  = tbl[k].amp;
        exp_pile = tbl[k].pile;
        exp_ts   = 32'(ts_at[tbl[k].ts_idx]);
        exp_cnt  = exp_cnt + 16'd1;
      end
      chk("amp_valid",   k, 32'(bus.amp_valid),   32'(tbl[k].v));
      chk("busy",        k, 32'(bus.busy),        32'(tbl[k].b));
      chk("amp_out",     k, 32'(bus.amp_out),     32'(exp_amp));
      chk("pileup",      k, 32'(bus.pileup),      32'(exp_pile));
      chk("timestamp",   k, bus.timestamp,        exp_ts);
      chk("event_count", k, 32'(bus.event_count), 32'(exp_cnt));
    end
  endtask

  initial begin
    int s;
    bus.in_data   = 16'sd0;
    bus.threshold = 16'sd100;

    // Reset state
    push(1'b0, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    push(1'b0, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    // Clean pulse
    add_clean();
    push(1'b1, 0, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    // Noise spike
    push(1'b1, 300, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 50, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    // Pile-up: 12 x 900, strobe on the 8th, WAIT_LOW, then 2-cycle holdoff
    add_prefix(s);
    for (int j = 1; j <= 12; j++)
      push(1'b1, 900, 100, (j == 8), 1'b1, 1010, 1'b1, s);
    push(1'b1, 0, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    // Second pulse 1 cycle after a strobe: late trigger, flat aborts
    add_clean();
    push(1'b1, 200, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 400, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    for (int j = 2; j < 8; j++) push(1'b1, vals[j], 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 500, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 50, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    // Second pulse 3 cycles after a strobe: measured
    add_clean();
    push(1'b1, 0, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    add_clean();
    push(1'b1, 0, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    // Threshold raised mid-FALL; equal value is not above -> strobe
    add_prefix(s);
    push(1'b1, 1000, 1000, 1'b1, 1'b1, 1010, 1'b0, s);
    push(1'b1, 900, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 900, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    // Signed compare: 50 > -100 triggers, -200 drops out
    push(1'b1, 50, -100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, -200, -100, 1'b0, 1'b0, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    // Reset during FLAT, then a clean pulse counts as event 1
    for (int j = 0; j < 6; j++) push(1'b1, vals[j], 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b0, 1010, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    add_clean();
    push(1'b1, 0, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    run_table();

    // Event counter wrap: preload 0xFFFF, one event -> 0x0000
    @(negedge clk);
    force dut.event_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.event_count_q;
    chk("count_preload", 0, 32'(bus.event_count), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    tbl.delete();
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    add_clean();
    push(1'b1, 0, 100, 1'b0, 1'b1, 0, 1'b0, 0);
    push(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    run_table();
    chk("count_wrap", 0, 32'(bus.event_count), 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
